af_hill_climb_ctrl: RTL
=======================

Name: af_hill_climb_ctrl

Overview:
- Autofocus search sequencer.
- Drives VCM target positions through a request/acknowledge handshake to the VCM I2C writer.
- Collects one per-frame sharpness sum from the pixel high-frequency statistics block for each position.
- Runs a coarse sweep, then a fine sweep around the coarse peak, then parks the lens at the best position found. All logic is in the video clock domain.

Parameters:
- POS_W, 10, VCM position width.
- SHARP_W, 32, sharpness accumulator width.
- POS_MIN, 0, lowest legal position.
- POS_MAX, 1023, highest legal position.
- COARSE_STEP, 64, coarse sweep increment.
- FINE_STEP, 8, fine sweep increment.
- SETTLE_FRAMES, 1, frames discarded after each acknowledged move (range 0..7).

Ports:
- VIDEO_CLK  in  1  pixel clock; the only clock.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; begins a search.
- ABORT  in  1  one-cycle pulse; cancels a search.
- FRAME_END  in  1  one-cycle pulse at the end of each frame's statistics window.
- SHARP_VALID  in  1  one-cycle pulse; SHARP is valid.
- SHARP  in  SHARP_W  frame sharpness sum.
- VCM_REQ  out  1  move request, held until acknowledged.
- VCM_POS  out  POS_W  target position; stable while VCM_REQ=1.
- VCM_ACK  in  1  one-cycle pulse; I2C write completed.
- BUSY  out  1  search in progress.
- DONE  out  1  one-cycle pulse when the final move is acknowledged.
- BEST_POS  out  POS_W  best position of the current or last search.
- BEST_SHARP  out  SHARP_W  sharpness at BEST_POS.
- PHASE  out  2  0=idle, 1=coarse, 2=fine, 3=final.

Behaviour:
- Reset values: all outputs 0; VCM_POS = POS_MIN; state IDLE.
- States: IDLE, MOVE, WAIT_ACK, SETTLE, MEASURE, ADVANCE, FINE_INIT, FINAL_MOVE, FINAL_ACK.
- IDLE: START -> load pos=POS_MIN, best_sharp=0, best_pos=POS_MIN, PHASE=1, go to MOVE. START is ignored in every other state.
- MOVE: assert VCM_REQ with VCM_POS=pos; go to WAIT_ACK.
- WAIT_ACK: hold VCM_REQ and VCM_POS. On VCM_ACK, deassert VCM_REQ on the next edge, load the settle counter with SETTLE_FRAMES, and go to SETTLE.
- SETTLE: each FRAME_END decrements the counter. At 0, go to MEASURE; with SETTLE_FRAMES=0 this happens immediately.
- MEASURE: wait for the first SHARP_VALID. SHARP_VALID outside MEASURE is ignored. If SHARP > best_sharp (strictly greater, so a tie keeps the earlier position), update best_sharp and best_pos. Go to ADVANCE.
- ADVANCE: next = pos + step, computed at POS_W+1 bits. step is COARSE_STEP in coarse phase, FINE_STEP in fine phase.
  - If next <= phase upper bound: pos=next, go to MOVE.
  - Else coarse -> FINE_INIT; fine -> FINAL_MOVE.
- FINE_INIT:
  - lo = max(best_pos - COARSE_STEP, POS_MIN), computed signed so there is no wrap below 0.
  - hi = min(best_pos + COARSE_STEP, POS_MAX).
  - pos = lo; PHASE=2; go to MOVE.
  - best_sharp and best_pos are retained, so a fine point must strictly beat the coarse peak.
- FINAL_MOVE: PHASE=3; VCM_POS=best_pos; VCM_REQ=1; go to FINAL_ACK.
- FINAL_ACK: on VCM_ACK, pulse DONE, clear BUSY, PHASE=0, go to IDLE.
- BUSY = 1 in every state except IDLE.
- ABORT in any non-IDLE state: next edge goes to IDLE, VCM_REQ=0, BUSY=0, no DONE. BEST_POS/BEST_SHARP hold their last values.
- Simultaneous events:
  - ABORT with VCM_ACK: ABORT wins.
  - FRAME_END with SHARP_VALID in the same cycle while in SETTLE with count 1: the SHARP is not used; measurement takes the next SHARP_VALID.
- Asynchronous reset mid-search: immediate return to the reset values; VCM_REQ drops asynchronously.
- Coarse upper bound is POS_MAX. Positions not on the step grid are never visited in that phase.
- Arithmetic: comparisons are unsigned at SHARP_W bits; SHARP saturation is the producer's responsibility.

Decomposition:
- Package af_pkg holds:
  - the state enumeration;
  - the PHASE encodings;
  - a clamp function for lo/hi.
- One sub-module, af_sweep_range: the position stepper. It loads lo/hi/step, produces the current pos, and raises a last flag when pos+step exceeds hi. The FSM stays in the top.

Test Plan:
- Coarse sweep and fine refinement:
  - Stimulus: POS_MIN=0, POS_MAX=1023, COARSE_STEP=64, FINE_STEP=8, SETTLE_FRAMES=1. Model SHARP = 100000 - 100*|pos-302|, ACK 5 cycles after REQ.
  - Response: 16 coarse moves (0..960) with coarse best 320; 17 fine moves (256..384); final VCM_POS=304, BEST_SHARP=99800, DONE once.
- Tie handling: flat SHARP=5000 at all positions -> BEST_POS=0 after coarse; fine window 0..64; final move to 0.
- Window clamp: peak at 1000 -> coarse best 960; fine window 896..1023 visits 896..1016; final 1000; no VCM_POS above 1023.
- Settle timing:
  - Stimulus: SETTLE_FRAMES=2; SHARP_VALID pulses arriving before the second FRAME_END after ACK.
  - Response: those pulses are ignored; the first SHARP_VALID after the second FRAME_END is used.
- ABORT and START handling:
  - ABORT asserted while in WAIT_ACK at pos=192 -> VCM_REQ low next cycle, BUSY=0, DONE never pulses.
  - A START pulse during a search changes nothing.
- Asynchronous reset: RESET_N low mid-SETTLE -> all outputs 0 without a clock edge; a fresh START restarts at pos 0.

Source files
------------

// File: rtl/af_pkg.sv
// Shared types and helpers for the autofocus hill-climb sequencer.
package af_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MOVE,
        ST_WAIT_ACK,
        ST_SETTLE,
        ST_MEASURE,
        ST_ADVANCE,
        ST_FINE_INIT,
        ST_FINAL_MOVE,
        ST_FINAL_ACK
    } af_state_e;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_COARSE = 2'd1,
        PH_FINE   = 2'd2,
        PH_FINAL  = 2'd3
    } af_phase_e;

    localparam int unsigned SETTLE_W = 3;

    // Signed offset from a centre position, clamped into [lo_lim, hi_lim].
    function automatic int clamp_window(input int centre, input int offset,
                                        input int lo_lim, input int hi_lim);
        int v;
        v = centre + offset;
        if (v < lo_lim) begin
            return lo_lim;
        end
        if (v > hi_lim) begin
            return hi_lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/af_sweep_range.sv
// Position stepper: walks pos from lo by step and flags the last point not beyond hi.
module af_sweep_range
    import af_pkg::*;
#(
    parameter int unsigned POS_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [POS_W-1:0] lo,
    input  logic [POS_W-1:0] hi,
    input  logic [POS_W-1:0] step,
    output logic [POS_W-1:0] pos,
    output logic             last_c
);

    logic [POS_W-1:0] hi_q;
    logic [POS_W-1:0] step_q;
    logic [POS_W:0]   next_c;

    // One extra bit so a step past the top of the range cannot wrap.
    assign next_c = {1'b0, pos} + {1'b0, step_q};
    assign last_c = (next_c > {1'b0, hi_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos    <= '0;
            hi_q   <= '0;
            step_q <= '0;
        end else if (load) begin
            pos    <= lo;
            hi_q   <= hi;
            step_q <= step;
        end else if (advance && !last_c) begin
            pos    <= next_c[POS_W-1:0];
        end
    end

endmodule

// File: rtl/af_hill_climb_ctrl.sv
// Autofocus search sequencer: coarse sweep, fine sweep around the coarse peak, then park at the best position.
module af_hill_climb_ctrl
    import af_pkg::*;
#(
    parameter int unsigned POS_W         = 10,
    parameter int unsigned SHARP_W       = 32,
    parameter int unsigned POS_MIN       = 0,
    parameter int unsigned POS_MAX       = 1023,
    parameter int unsigned COARSE_STEP   = 64,
    parameter int unsigned FINE_STEP     = 8,
    parameter int unsigned SETTLE_FRAMES = 1
) (
    input  logic               VIDEO_CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic               FRAME_END,
    input  logic               SHARP_VALID,
    input  logic [SHARP_W-1:0] SHARP,
    output logic               VCM_REQ,
    output logic [POS_W-1:0]   VCM_POS,
    input  logic               VCM_ACK,
    output logic               BUSY,
    output logic               DONE,
    output logic [POS_W-1:0]   BEST_POS,
    output logic [SHARP_W-1:0] BEST_SHARP,
    output logic [1:0]         PHASE
);

    af_state_e           state_q, state_d;
    af_phase_e           phase_q, phase_d;
    logic                req_q, req_d;
    logic [POS_W-1:0]    vcm_pos_q, vcm_pos_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [POS_W-1:0]    best_pos_q, best_pos_d;
    logic [SHARP_W-1:0]  best_sharp_q, best_sharp_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    logic                load_c;
    logic                adv_c;
    logic [POS_W-1:0]    lo_c;
    logic [POS_W-1:0]    hi_c;
    logic [POS_W-1:0]    step_c;
    logic [POS_W-1:0]    sweep_pos;
    logic                sweep_last_c;

    af_sweep_range #(
        .POS_W (POS_W)
    ) u_sweep (
        .clk     (VIDEO_CLK),
        .rst_n   (RESET_N),
        .load    (load_c),
        .advance (adv_c),
        .lo      (lo_c),
        .hi      (hi_c),
        .step    (step_c),
        .pos     (sweep_pos),
        .last_c  (sweep_last_c)
    );

    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_IDLE;
            req_q        <= 1'b0;
            vcm_pos_q    <= POS_W'(POS_MIN);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            best_pos_q   <= '0;
            best_sharp_q <= '0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            req_q        <= req_d;
            vcm_pos_q    <= vcm_pos_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            best_pos_q   <= best_pos_d;
            best_sharp_q <= best_sharp_d;
            settle_q     <= settle_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        req_d        = req_q;
        vcm_pos_d    = vcm_pos_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        best_pos_d   = best_pos_q;
        best_sharp_d = best_sharp_q;
        settle_d     = settle_q;
        load_c       = 1'b0;
        adv_c        = 1'b0;
        lo_c         = POS_W'(POS_MIN);
        hi_c         = POS_W'(POS_MAX);
        step_c       = POS_W'(COARSE_STEP);

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    load_c       = 1'b1;
                    best_sharp_d = '0;
                    best_pos_d   = POS_W'(POS_MIN);
                    phase_d      = PH_COARSE;
                    busy_d       = 1'b1;
                    state_d      = ST_MOVE;
                end
            end
            ST_MOVE: begin
                req_d     = 1'b1;
                vcm_pos_d = sweep_pos;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (VCM_ACK) begin
                    req_d    = 1'b0;
                    settle_d = SETTLE_W'(SETTLE_FRAMES);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_MEASURE;
                end else if (FRAME_END) begin
                    settle_d = settle_q - SETTLE_W'(1);
                    if (settle_q == SETTLE_W'(1)) begin
                        state_d = ST_MEASURE;
                    end
                end
            end
            ST_MEASURE: begin
                if (SHARP_VALID) begin
                    // Strictly greater: a tie keeps the earlier position.
                    if (SHARP > best_sharp_q) begin
                        best_sharp_d = SHARP;
                        best_pos_d   = sweep_pos;
                    end
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (!sweep_last_c) begin
                    adv_c   = 1'b1;
                    state_d = ST_MOVE;
                end else if (phase_q == PH_COARSE) begin
                    state_d = ST_FINE_INIT;
                end else begin
                    state_d = ST_FINAL_MOVE;
                end
            end
            ST_FINE_INIT: begin
                load_c  = 1'b1;
                lo_c    = POS_W'(clamp_window(int'(best_pos_q), -int'(COARSE_STEP),
                                              int'(POS_MIN), int'(POS_MAX)));
                hi_c    = POS_W'(clamp_window(int'(best_pos_q), int'(COARSE_STEP),
                                              int'(POS_MIN), int'(POS_MAX)));
                step_c  = POS_W'(FINE_STEP);
                phase_d = PH_FINE;
                state_d = ST_MOVE;
            end
            ST_FINAL_MOVE: begin
                phase_d   = PH_FINAL;
                vcm_pos_d = best_pos_q;
                req_d     = 1'b1;
                state_d   = ST_FINAL_ACK;
            end
            ST_FINAL_ACK: begin
                if (VCM_ACK) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    phase_d = PH_IDLE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a coincident acknowledge or sample.
        if (ABORT && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            phase_d      = PH_IDLE;
            req_d        = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            best_pos_d   = best_pos_q;
            best_sharp_d = best_sharp_q;
            load_c       = 1'b0;
            adv_c        = 1'b0;
        end
    end

    assign VCM_REQ    = req_q;
    assign VCM_POS    = vcm_pos_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign BEST_POS   = best_pos_q;
    assign BEST_SHARP = best_sharp_q;
    assign PHASE      = phase_q;

endmodule
